// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings, the default
// operand width and the quotient fill value reported on divide-by-zero.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        DONE_S = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Every quotient bit is forced to this value when the divisor is zero.
    localparam logic DBZ_QUOTIENT_BIT = 1'b1;

endpackage

// File: rtl/iterative_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-2:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    assign shifted = {rem_in, bit_in};
    assign trial   = {1'b0, shifted} - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted;

endmodule

// File: rtl/iterative_divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock, with a
// START/BUSY/DONE handshake. Define DIVIDER_SIGNED_EN for two's-complement operands.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Between iterations the partial remainder is below 2^(WIDTH-1), so its top bit is never kept.
    logic [WIDTH-2:0] rem_q, rem_d;
    logic [WIDTH-1:0] qsr_q, qsr_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_step;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] qsr_shift;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rmd_final;

    assign accept    = START && ((state_q == IDLE) || (state_q == DONE_S));
    assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(1));
    assign qsr_shift = {qsr_q[WIDTH-2:0], step_bit};

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .bit_in  (qsr_q[WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

`ifdef DIVIDER_SIGNED_EN
    logic sq_q, sq_d;
    logic sr_q, sr_d;

    assign dividend_mag = DATA1[WIDTH-1] ? (~DATA1 + WIDTH'(1)) : DATA1;
    assign divisor_mag  = DATA2[WIDTH-1] ? (~DATA2 + WIDTH'(1)) : DATA2;
    assign quo_final    = sq_q ? (~qsr_shift + WIDTH'(1)) : qsr_shift;
    assign rmd_final    = sr_q ? (~step_rem + WIDTH'(1)) : step_rem;

    always_comb begin
        sq_d = sq_q;
        sr_d = sr_q;
        if (accept) begin
            sq_d = DATA1[WIDTH-1] ^ DATA2[WIDTH-1];
            sr_d = DATA1[WIDTH-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            sq_q <= 1'b0;
            sr_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
            sr_q <= sr_d;
        end
    end
`else
    assign dividend_mag = DATA1;
    assign divisor_mag  = DATA2;
    assign quo_final    = qsr_shift;
    assign rmd_final    = step_rem;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = (DATA2 == '0) ? DONE_S : CALC;
                end
            end
            CALC: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE_S;
                end
            end
            DONE_S: begin
                if (START) begin
                    state_d = (DATA2 == '0) ? DONE_S : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        unique case (state_q)
            CALC:    BUSY = 1'b1;
            DONE_S:  DONE = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        qsr_d = qsr_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        dbz_d = dbz_q;
        if (accept) begin
            qsr_d = dividend_mag;
            dvs_d = divisor_mag;
            rem_d = '0;
            cnt_d = CNT_W'(WIDTH);
            quo_d = '0;
            rmd_d = '0;
            dbz_d = 1'b0;
            // A zero divisor skips CALC, so its results are posted on the accept edge.
            if (DATA2 == '0) begin
                quo_d = {WIDTH{DBZ_QUOTIENT_BIT}};
                rmd_d = DATA1;
                dbz_d = 1'b1;
            end
        end else if (state_q == CALC) begin
            rem_d = step_rem[WIDTH-2:0];
            qsr_d = qsr_shift;
            cnt_d = cnt_q - CNT_W'(1);
            if (last_step) begin
                quo_d = quo_final;
                rmd_d = rmd_final;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q <= '0;
            rem_q <= '0;
            qsr_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            qsr_q <= qsr_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rmd_q <= rmd_d;
            dbz_q <= dbz_d;
        end
    end

    assign QUOTIENT    = quo_q;
    assign REMAINDER   = rmd_q;
    assign DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: expected {DIV_BY_ZERO, QUOTIENT, REMAINDER}
// tuples are queued at issue time and compared whenever DONE is observed.
module tb_iterative_divider;

    localparam int W = 8;

    logic         CLK;
    logic         RESET;
    logic         START;
    logic [W-1:0] DATA1;
    logic [W-1:0] DATA2;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] QUOTIENT;
    logic [W-1:0] REMAINDER;
    logic         DIV_BY_ZERO;

    int checks = 0;
    int errors = 0;

    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_exp;
    logic [2*W:0] mon_got;

    iterative_divider #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .DATA1       (DATA1),
        .DATA2       (DATA2),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .DIV_BY_ZERO (DIV_BY_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: {dbz, quotient, remainder}
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q;
        logic [W-1:0] r;
`ifdef DIVIDER_SIGNED_EN
        int sa;
        int sb;
`endif
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef DIVIDER_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
`else
        q = a / b;
        r = a % b;
`endif
        return {1'b0, q, r};
    endfunction

    // Scoreboard: every DONE cycle consumes one queued expectation
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            mon_got = {DIV_BY_ZERO, QUOTIENT, REMAINDER};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got dbz=%0b q=%0d r=%0d, required no DONE",
                         DIV_BY_ZERO, QUOTIENT, REMAINDER);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got dbz=%0b q=%0d r=%0d, required dbz=%0b q=%0d r=%0d",
                             mon_got[2*W], mon_got[2*W-1:W], mon_got[W-1:0],
                             mon_exp[2*W], mon_exp[2*W-1:W], mon_exp[W-1:0]);
                end else begin
                    $display("txn: dbz=%0b q=%0d r=%0d ok", mon_got[2*W], mon_got[2*W-1:W], mon_got[W-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a request through one accepting edge; operands are scrambled afterwards.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        if (push) exp_q.push_back(model(a, b));
        START = 1'b1;
        DATA1 = a;
        DATA2 = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        DATA1 = W'($urandom);
        DATA2 = W'($urandom);
    endtask

    // Returns at the negedge where DONE is seen, or flags a timeout.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: DONE=0 after %0d cycles, required DONE=1", name, 3 * W);
        end
    endtask

    task automatic go_idle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        START = 1'b1;
        DATA1 = 8'd15;
        DATA2 = 8'd4;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, DIV_BY_ZERO, QUOTIENT, REMAINDER} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all 0",
                     BUSY, DONE, DIV_BY_ZERO, QUOTIENT, REMAINDER);
        end
        START = 1'b0;
        RESET = 1'b1;
        go_idle();
    endtask

    task automatic test_basic();
        issue(8'd15, 8'd4, 1'b1);
        for (int i = 0; i <= W; i++) begin
            @(negedge CLK);
            checks++;
            if ({BUSY, DONE} !== ((i < W) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL latency_cycle%0d: got busy=%0b done=%0b, required busy=%0b done=%0b",
                         i, BUSY, DONE, i < W, i == W);
            end
        end
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || QUOTIENT !== 8'd3 || REMAINDER !== 8'd3) begin
            errors++;
            $display("FAIL done_pulse_hold: got done=%0b q=%0d r=%0d, required done=0 q=3 r=3",
                     DONE, QUOTIENT, REMAINDER);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        issue(8'd200, 8'd7, 1'b1);
        wait_done("b2b_first");
        issue(8'd255, 8'd255, 1'b1);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b1 || QUOTIENT !== '0) begin
            errors++;
            $display("FAIL b2b_no_gap: got busy=%0b q=%0d, required busy=1 q=0", BUSY, QUOTIENT);
        end
        wait_done("b2b_second");
        go_idle();
    endtask

    task automatic test_div_zero();
        bit busy_seen;
        busy_seen = 1'b0;
        issue(8'd5, 8'd0, 1'b1);
        @(negedge CLK);
        busy_seen = BUSY;
        checks++;
        if (DONE !== 1'b1 || DIV_BY_ZERO !== 1'b1 || QUOTIENT !== 8'hFF || REMAINDER !== 8'd5) begin
            errors++;
            $display("FAIL dbz_one_edge: got done=%0b dbz=%0b q=%0h r=%0d, required done=1 dbz=1 q=ff r=5",
                     DONE, DIV_BY_ZERO, QUOTIENT, REMAINDER);
        end
        go_idle();
        @(negedge CLK);
        busy_seen = busy_seen | BUSY;
        checks++;
        if (busy_seen !== 1'b0 || DONE !== 1'b0 || DIV_BY_ZERO !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: got busy_seen=%0b done=%0b dbz=%0b, required 0 0 1",
                     busy_seen, DONE, DIV_BY_ZERO);
        end
    endtask

    task automatic test_start_ignored();
        issue(8'd100, 8'd9, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        START = 1'b1;
        DATA1 = 8'd50;
        DATA2 = 8'd5;
        @(posedge CLK);
        #1;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL ignored_start_busy: got busy=%0b, required 1", BUSY);
        end
        wait_done("ignored_start");
        go_idle();
    endtask

    task automatic test_reset_abort();
        bit done_seen;
        done_seen = 1'b0;
        issue(8'd100, 8'd9, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if ({BUSY, DONE, DIV_BY_ZERO, QUOTIENT, REMAINDER} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%0b done=%0b dbz=%0b q=%0d r=%0d, required all 0",
                     BUSY, DONE, DIV_BY_ZERO, QUOTIENT, REMAINDER);
        end
        RESET = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge CLK);
            done_seen = done_seen | DONE;
        end
        checks++;
        if (done_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done_seen=%0b, required 0", done_seen);
        end
        issue(8'd9, 8'd3, 1'b1);
        wait_done("after_abort");
        go_idle();
    endtask

    task automatic test_boundaries();
        logic [W-1:0] a_tab[4] = '{8'd3, 8'd77, 8'd123, 8'd0};
        logic [W-1:0] b_tab[4] = '{8'd10, 8'd77, 8'd1, 8'd13};
        for (int i = 0; i < 4; i++) begin
            issue(a_tab[i], b_tab[i], 1'b1);
            wait_done("boundary");
            go_idle();
        end
        for (int i = 0; i < 8; i++) begin
            issue(W'($urandom), W'($urandom_range(0, 255)), 1'b1);
            wait_done("random");
            go_idle();
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] a_tab[3] = '{8'hF9, 8'h07, 8'h80};
        logic [W-1:0] b_tab[3] = '{8'h02, 8'hFE, 8'hFF};
        logic [2*W:0] e_tab[3] = '{{1'b0, 8'hFD, 8'hFF}, {1'b0, 8'hFD, 8'h01}, {1'b0, 8'h80, 8'h00}};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e_tab[i]);
            issue(a_tab[i], b_tab[i], 1'b0);
            wait_done("signed");
            go_idle();
        end
    endtask
`endif

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        DATA1 = '0;
        DATA2 = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_reset_abort();
        test_boundaries();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        repeat (2) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
